// File: rtl/controller.sv
// Multicycle control FSM for the 16-bit datapath, driving register, ALU, PC and memory controls.
// Latency: 3 to 6 cycles per instruction; outputs are registered and valid the cycle the state is entered.
// Backpressure: none; the FSM advances every cycle, and reset aborts any instruction in progress.
module controller #(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         instruction,
  input  logic [WIDTH-1:0]         psr_flags,
  output logic                     reg_write,
  output logic                     pc_en,
  output logic                     alu_A_src,
  output logic                     alu_B_src,
  output logic                     pc_src,
  output logic                     reg_write_src,
  output logic [ALU_CONT_BITS-1:0] alu_cont,
  output logic                     psr_en,
  output logic                     ir_load,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [1:0]               mem_addr_src
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB, S_LOAD_RD, S_LOAD_WAIT,
    S_LOAD_WB, S_STORE, S_BRANCH, S_JUMP, S_PC_INC
  } state_t;

  localparam logic [ALU_CONT_BITS-1:0] ALU_ADD   = ALU_CONT_BITS'(0);
  localparam logic [ALU_CONT_BITS-1:0] ALU_SUB   = ALU_CONT_BITS'(1);
  localparam logic [ALU_CONT_BITS-1:0] ALU_AND   = ALU_CONT_BITS'(2);
  localparam logic [ALU_CONT_BITS-1:0] ALU_OR    = ALU_CONT_BITS'(3);
  localparam logic [ALU_CONT_BITS-1:0] ALU_XOR   = ALU_CONT_BITS'(4);
  localparam logic [ALU_CONT_BITS-1:0] ALU_PASSB = ALU_CONT_BITS'(5);
  localparam logic [ALU_CONT_BITS-1:0] ALU_INC   = ALU_CONT_BITS'(6);

  // ALU operation code: R-type carries it in ext, I-type in op.
  function automatic logic code_valid(input logic [3:0] c);
    case (c)
      4'b0101, 4'b1001, 4'b0001, 4'b0010, 4'b0011, 4'b1011, 4'b1101: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [ALU_CONT_BITS-1:0] code_alu(input logic [3:0] c);
    case (c)
      4'b0101: return ALU_ADD;
      4'b1001, 4'b1011: return ALU_SUB;  // CMP is a SUB without writeback
      4'b0001: return ALU_AND;
      4'b0010: return ALU_OR;
      4'b0011: return ALU_XOR;
      4'b1101: return ALU_PASSB;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic code_sets_flags(input logic [3:0] c);
    return (c == 4'b0101) || (c == 4'b1001) || (c == 4'b1011);
  endfunction

  state_t           state, nxt;
  logic [WIDTH-1:0] ir;
  logic             armed;  // low for the first cycle after reset so FETCH is held once with live outputs
  logic [WIDTH-1:0] cur_ins;
  logic [3:0]       op, ext, cond, alu_code;
  logic             taken;

  logic                     n_reg_write, n_pc_en, n_alu_A_src, n_alu_B_src, n_pc_src;
  logic                     n_reg_write_src, n_psr_en, n_ir_load, n_mem_read, n_mem_write;
  logic [ALU_CONT_BITS-1:0] n_alu_cont;
  logic [1:0]               n_mem_addr_src;

  logic unused_bits;
  assign unused_bits = ^{psr_flags[WIDTH-1:7], psr_flags[5:0], cur_ins[3:0]};

  // Next state and the control vector of that state, decoded from the live bus in DECODE and from the copy afterwards.
  always_comb begin
    cur_ins  = (state == S_DECODE) ? instruction : ir;
    op       = cur_ins[15:12];
    ext      = cur_ins[7:4];
    cond     = cur_ins[11:8];
    alu_code = (op == 4'b0000) ? ext : op;
    taken    = ((cond == 4'b0000) &&  psr_flags[6]) ||
               ((cond == 4'b0001) && !psr_flags[6]) ||
                (cond == 4'b1110);

    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        nxt = S_PC_INC;
        if (op == 4'b0000 && code_valid(ext))      nxt = S_EXEC_R;
        else if (op != 4'b0000 && code_valid(op)) nxt = S_EXEC_I;
        else if (op == 4'b0100) begin
          if (ext == 4'b0000)      nxt = S_LOAD_RD;
          else if (ext == 4'b0100) nxt = S_STORE;
          else if (ext == 4'b1100) nxt = S_JUMP;
        end else if (op == 4'b1100) nxt = S_BRANCH;
      end
      S_EXEC_R, S_EXEC_I: nxt = (alu_code == 4'b1011) ? S_PC_INC : S_WB;
      S_WB:        nxt = S_PC_INC;
      S_LOAD_RD:   nxt = S_LOAD_WAIT;
      S_LOAD_WAIT: nxt = S_LOAD_WB;
      S_LOAD_WB:   nxt = S_PC_INC;
      S_STORE:     nxt = S_PC_INC;
      default:     nxt = S_FETCH;  // BRANCH, JUMP, PC_INC
    endcase
    if (!armed) nxt = S_FETCH;

    n_reg_write = 1'b0; n_pc_en = 1'b0; n_alu_A_src = 1'b0; n_alu_B_src = 1'b0;
    n_pc_src = 1'b0; n_reg_write_src = 1'b0; n_alu_cont = ALU_ADD; n_psr_en = 1'b0;
    n_ir_load = 1'b0; n_mem_read = 1'b0; n_mem_write = 1'b0; n_mem_addr_src = 2'd0;
    case (nxt)
      S_FETCH:  n_mem_read = 1'b1;
      S_DECODE: n_ir_load = 1'b1;
      S_EXEC_R, S_EXEC_I: begin
        n_alu_A_src = 1'b1;
        n_alu_B_src = (nxt == S_EXEC_I);
        n_alu_cont  = code_alu(alu_code);
        n_psr_en    = code_sets_flags(alu_code);
      end
      S_WB:      n_reg_write = 1'b1;
      S_LOAD_RD: begin n_mem_read = 1'b1; n_mem_addr_src = 2'd2; end
      S_LOAD_WB: begin n_reg_write = 1'b1; n_reg_write_src = 1'b1; end
      S_STORE:   begin n_mem_write = 1'b1; n_mem_addr_src = 2'd1; end
      S_BRANCH: begin
        n_pc_en     = 1'b1;
        n_alu_B_src = taken;
        n_alu_cont  = taken ? ALU_ADD : ALU_INC;
      end
      S_JUMP:   begin n_pc_src = 1'b1; n_pc_en = 1'b1; end
      S_PC_INC: begin n_pc_en = 1'b1; n_alu_cont = ALU_INC; end
      default: ;
    endcase
  end

  // State, instruction copy and registered control outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH; ir <= '0; armed <= 1'b0;
      reg_write <= 1'b0; pc_en <= 1'b0; alu_A_src <= 1'b0; alu_B_src <= 1'b0;
      pc_src <= 1'b0; reg_write_src <= 1'b0; alu_cont <= '0; psr_en <= 1'b0;
      ir_load <= 1'b0; mem_read <= 1'b0; mem_write <= 1'b0; mem_addr_src <= 2'd0;
    end else begin
      state <= nxt;
      armed <= 1'b1;
      if (state == S_DECODE) ir <= instruction;
      reg_write <= n_reg_write; pc_en <= n_pc_en; alu_A_src <= n_alu_A_src;
      alu_B_src <= n_alu_B_src; pc_src <= n_pc_src; reg_write_src <= n_reg_write_src;
      alu_cont <= n_alu_cont; psr_en <= n_psr_en; ir_load <= n_ir_load;
      mem_read <= n_mem_read; mem_write <= n_mem_write; mem_addr_src <= n_mem_addr_src;
    end
  end

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: per-cycle control vectors for each instruction class.
// Outputs sampled on the falling edge, inputs changed on the falling edge.
// One task per scenario, run back to back so every task starts on a FETCH cycle.
module tb_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] psr_flags;
  logic        reg_write, pc_en, alu_A_src, alu_B_src, pc_src, reg_write_src;
  logic [4:0]  alu_cont;
  logic        psr_en, ir_load, mem_read, mem_write;
  logic [1:0]  mem_addr_src;

  int tests = 0;
  int fails = 0;

  controller #(.WIDTH(16), .ALU_CONT_BITS(5)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .psr_flags(psr_flags),
    .reg_write(reg_write), .pc_en(pc_en), .alu_A_src(alu_A_src), .alu_B_src(alu_B_src),
    .pc_src(pc_src), .reg_write_src(reg_write_src), .alu_cont(alu_cont), .psr_en(psr_en),
    .ir_load(ir_load), .mem_read(mem_read), .mem_write(mem_write), .mem_addr_src(mem_addr_src)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {reg_write, pc_en, alu_A_src, alu_B_src, pc_src, reg_write_src,
                alu_cont, psr_en, ir_load, mem_read, mem_write, mem_addr_src};

  // Field order: reg_write pc_en alu_A alu_B pc_src rw_src alu_cont psr_en ir_load mem_read mem_write addr_src
  function automatic logic [16:0] ev(input logic rw, pe, as_, bs, ps, rws, input logic [4:0] ac,
                                     input logic pse, irl, mr, mw, input logic [1:0] mas);
    return {rw, pe, as_, bs, ps, rws, ac, pse, irl, mr, mw, mas};
  endfunction

  logic [16:0] V_FETCH, V_DECODE, V_PCINC, V_WB, V_ZERO;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [16:0] e[3];
    reset = 1'b1; instruction = 16'hF000; psr_flags = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs !== V_ZERO) begin
        fails++; $display("FAIL reset cycle %0d: got %h want %h", i, obs, V_ZERO);
      end
    end
    reset = 1'b0;
    // first instruction is a NOP: FETCH, DECODE, PC_INC
    e[0] = V_FETCH; e[1] = V_DECODE; e[2] = V_PCINC;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs !== e[i]) begin
        fails++; $display("FAIL reset_then_nop cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_alu_r;
    logic [16:0] e[5];
    instruction = 16'h0152;  // ADD R1,R2
    e[0] = V_FETCH; e[1] = V_DECODE; e[2] = ev(0,0,1,0,0,0,5'd0,1,0,0,0,2'd0);
    e[3] = V_WB; e[4] = V_PCINC;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (obs !== e[i]) begin
        fails++; $display("FAIL add cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
    instruction = 16'h0132;  // XOR: no flag update
    e[2] = ev(0,0,1,0,0,0,5'd4,0,0,0,0,2'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (obs !== e[i]) begin
        fails++; $display("FAIL xor cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_cmp;
    logic [16:0] e[4];
    instruction = 16'h01B2;  // CMP: SUB with flags, no writeback
    e[0] = V_FETCH; e[1] = V_DECODE; e[2] = ev(0,0,1,0,0,0,5'd1,1,0,0,0,2'd0); e[3] = V_PCINC;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (obs !== e[i]) begin
        fails++; $display("FAIL cmp cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_alu_i;
    logic [16:0] e[5];
    instruction = 16'h5107;  // ADDI
    e[0] = V_FETCH; e[1] = V_DECODE; e[2] = ev(0,0,1,1,0,0,5'd0,1,0,0,0,2'd0);
    e[3] = V_WB; e[4] = V_PCINC;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (obs !== e[i]) begin
        fails++; $display("FAIL addi cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
    instruction = 16'hD107;  // MOVI: PASSB, no flags
    e[2] = ev(0,0,1,1,0,0,5'd5,0,0,0,0,2'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (obs !== e[i]) begin
        fails++; $display("FAIL movi cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_load;
    logic [16:0] e[6];
    instruction = 16'h4103;
    e[0] = V_FETCH; e[1] = V_DECODE; e[2] = ev(0,0,0,0,0,0,5'd0,0,0,1,0,2'd2);
    e[3] = V_ZERO; e[4] = ev(1,0,0,0,0,1,5'd0,0,0,0,0,2'd0); e[5] = V_PCINC;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (obs !== e[i]) begin
        fails++; $display("FAIL load cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_store;
    logic [16:0] e[4];
    instruction = 16'h4142;
    e[0] = V_FETCH; e[1] = V_DECODE; e[2] = ev(0,0,0,0,0,0,5'd0,0,0,0,1,2'd1); e[3] = V_PCINC;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (obs !== e[i]) begin
        fails++; $display("FAIL stor cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_branch;
    logic [16:0] taken_v, e[3];
    logic [15:0] ins[4];
    logic [15:0] flg[4];
    logic        tk[4];
    taken_v = ev(0,1,0,1,0,0,5'd0,0,0,0,0,2'd0);
    ins[0] = 16'hC005; flg[0] = 16'h0040; tk[0] = 1'b1;  // EQ, Z=1
    ins[1] = 16'hC005; flg[1] = 16'h0000; tk[1] = 1'b0;  // EQ, Z=0
    ins[2] = 16'hC105; flg[2] = 16'hFFBF; tk[2] = 1'b1;  // NE, Z=0, other flags ignored
    ins[3] = 16'hC305; flg[3] = 16'h0040; tk[3] = 1'b0;  // unsupported cond
    for (int k = 0; k < 4; k++) begin
      instruction = ins[k]; psr_flags = flg[k];
      e[0] = V_FETCH; e[1] = V_DECODE; e[2] = tk[k] ? taken_v : V_PCINC;
      for (int i = 0; i < 3; i++) begin
        tick();
        tests++;
        if (obs !== e[i]) begin
          fails++; $display("FAIL branch%0d cycle %0d: got %h want %h", k, i, obs, e[i]);
        end
      end
    end
    psr_flags = 16'h0000;
  endtask

  task automatic test_jump;
    logic [16:0] e[3];
    instruction = 16'h4AC7;
    e[0] = V_FETCH; e[1] = V_DECODE; e[2] = ev(0,1,0,0,1,0,5'd0,0,0,0,0,2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (obs !== e[i]) begin
        fails++; $display("FAIL jump cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load;
    logic [16:0] e[4];
    instruction = 16'h4103;
    e[0] = V_FETCH; e[1] = V_DECODE; e[2] = ev(0,0,0,0,0,0,5'd0,0,0,1,0,2'd2); e[3] = V_ZERO;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (obs !== e[i]) begin
        fails++; $display("FAIL midreset_load cycle %0d: got %h want %h", i, obs, e[i]);
      end
    end
    reset = 1'b1;  // during LOAD_WAIT
    tick();
    tests++;
    if (obs !== V_ZERO) begin
      fails++; $display("FAIL midreset_zero: got %h want %h", obs, V_ZERO);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (obs !== V_FETCH) begin
      fails++; $display("FAIL midreset_fetch: got %h want %h", obs, V_FETCH);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    V_FETCH  = ev(0,0,0,0,0,0,5'd0,0,0,1,0,2'd0);
    V_DECODE = ev(0,0,0,0,0,0,5'd0,0,1,0,0,2'd0);
    V_PCINC  = ev(0,1,0,0,0,0,5'd6,0,0,0,0,2'd0);
    V_WB     = ev(1,0,0,0,0,0,5'd0,0,0,0,0,2'd0);
    V_ZERO   = 17'd0;
    reset = 1'b1; instruction = 16'hF000; psr_flags = 16'h0000;
    @(negedge clk);
    test_reset();
    test_alu_r();
    test_cmp();
    test_alu_i();
    test_load();
    test_store();
    test_branch();
    test_jump();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controller.md
Name: controller

Overview:
Multicycle control FSM that drives the 16-bit datapath's control inputs: register writes, mux selects, ALU operation and PC enable. It also issues memory read/write strobes and address selects for the shared synchronous memory. It sits beside the datapath: it takes the raw instruction and latched PSR flags, and returns one control vector per cycle.

Parameters:
WIDTH, 16, instruction/flag width
ALU_CONT_BITS, 5, width of alu_cont

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
instruction  in  WIDTH  instruction bus, valid in DECODE
psr_flags  in  WIDTH  latched flags; bit6=Z, others ignored
reg_write  out  1  register file write enable
pc_en  out  1  PC load enable
alu_A_src  out  1  0=pc, 1=reg_A
alu_B_src  out  1  0=reg_B, 1=immediate
pc_src  out  1  0=alu_out, 1=B_data
reg_write_src  out  1  0=reg_alu, 1=reg_mdr
alu_cont  out  ALU_CONT_BITS  ALU op: ADD=0, SUB=1, AND=2, OR=3, XOR=4, PASSB=5, INC=6
psr_en  out  1  flag register load enable
ir_load  out  1  external instruction latch enable
mem_read  out  1  memory read strobe (1-cycle sync read latency)
mem_write  out  1  memory write strobe
mem_addr_src  out  2  0=pc, 1=reg_A, 2=reg_B

Behaviour:
- Decoding: op=[15:12], ext=[7:4]. The instruction is latched internally in DECODE; later states decode from that copy.
- R-type (op 0000): ext 0101 ADD, 1001 SUB, 0001 AND, 0010 OR, 0011 XOR, 1011 CMP, 1101 MOV(PASSB).
- I-type: op equals the R-type ext code for the same op, with alu_B_src=1.
- op 0100: ext 0000 LOAD (Rdest=[11:8], Raddr=[3:0]); ext 0100 STOR (Raddr=[11:8], Rsrc=[3:0]); ext 1100 JUMP (target Rsrc=[3:0]).
- op 1100 Bcond: cond=[11:8]. 0000 EQ (Z=1), 0001 NE (Z=0), 1110 always; any other cond is not taken.
- Any other opcode/ext combination is a NOP and goes to PC_INC.
- Outputs are Moore (state plus latched instruction). Any output not listed for a state is 0.
- FETCH: mem_read=1, mem_addr_src=0. Next state is DECODE.
- DECODE: ir_load=1. Datapath A/B/imm flops capture this cycle. Branches to EXEC_R, EXEC_I, LOAD_RD, STORE, BRANCH, JUMP or PC_INC.
- EXEC_R / EXEC_I: alu_A_src=1, alu_B_src=0 or 1 respectively, alu_cont per op.
  - psr_en=1 for ADD, SUB, CMP.
  - CMP uses SUB and goes to PC_INC (no writeback); all others go to WB.
- WB: reg_write=1, reg_write_src=0. Next state is PC_INC.
- LOAD_RD: mem_read=1, mem_addr_src=2. Next is LOAD_WAIT (MDR captures), then LOAD_WB: reg_write=1, reg_write_src=1, then PC_INC.
- STORE: mem_write=1, mem_addr_src=1. Next state is PC_INC.
- BRANCH: pc_en=1, alu_A_src=0.
  - Taken: alu_B_src=1, alu_cont=ADD, so PC = instruction address + sign-extended imm.
  - Not taken: alu_cont=INC.
  - Next state is FETCH.
- JUMP: pc_src=1, pc_en=1. Next state is FETCH.
- PC_INC: alu_A_src=0, alu_cont=INC, pc_src=0, pc_en=1. Next state is FETCH.
- Instruction latency in cycles:
  - ALU op: 5
  - CMP: 4
  - LOAD: 6
  - STOR: 4
  - Bcond/JUMP: 3
  - NOP: 3
- reset has priority over every state, including mid-instruction: state goes to FETCH, the internal instruction copy clears to 0, and all outputs are 0 while reset is high. The first cycle after deassertion is FETCH.
- pc_en, reg_write and mem_write are never asserted in FETCH or DECODE.
- pc_en is asserted exactly once per instruction.
- reg_write and mem_write are never asserted together.

Test Plan:
- Reset held 3 cycles, then released → all outputs 0 during reset; next cycle mem_read=1, mem_addr_src=0 (FETCH).
- Instruction 0x0152 (ADD R1,R2) → states FETCH, DECODE, EXEC_R (alu_cont=0, psr_en=1), WB (reg_write=1), PC_INC (pc_en=1, alu_cont=6), in 5 cycles.
- 0x4103 (LOAD R1,[R3]) → mem_read with mem_addr_src=2 in cycle 3; reg_write=1, reg_write_src=1 in cycle 5; pc_en in cycle 6.
- 0xC005 with psr_flags=0x0040 → BRANCH with alu_B_src=1, alu_cont=0, pc_en=1. Same instruction with psr_flags=0 → alu_cont=6. Both return to FETCH after 3 cycles.
- 0x4ACx (JUMP) → pc_src=1, pc_en=1 in cycle 3. 0xF000 → NOP path: FETCH, DECODE, PC_INC.
- Reset asserted during LOAD_WAIT → outputs 0 the next cycle, no reg_write; FETCH on the cycle after reset deasserts.
